// File: rtl/cpu_phase_sequencer_if.sv
// cpu_phase_sequencer_if: control, memory handshake and status bundle between the
// instruction sequencer (master) and the datapath/memory side (slave).
interface cpu_phase_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int STEP_W = 3
);
    logic              stop;
    logic              run_req;
    logic [DATA_W-1:0] ir;
    logic [STEP_W-1:0] exec_len;
    logic              step_mem;
    logic              mem_ready;
    logic              mem_req;
    logic [2:0]        phase;
    logic [STEP_W-1:0] step;
    logic              pcout_marin;
    logic              incpc;
    logic              mdrin;
    logic              irin;
    logic              run;
    logic              bus_err;
    logic [31:0]       instr_count;

    modport master (
        input  stop, run_req, ir, exec_len, step_mem, mem_ready,
        output mem_req, phase, step, pcout_marin, incpc, mdrin, irin, run, bus_err, instr_count
    );

    modport slave (
        output stop, run_req, ir, exec_len, step_mem, mem_ready,
        input  mem_req, phase, step, pcout_marin, incpc, mdrin, irin, run, bus_err, instr_count
    );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: fetch/decode/execute sequencer with variable-length execute steps,
// memory request timeout, halt/run control and a retired-instruction counter.
module cpu_phase_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OPW     = 5,
    parameter int HALT_OP = 27,
    parameter int STEP_W  = 3,
    parameter int TIMEOUT = 15
) (
    input logic                   clk,
    input logic                   rst,
    cpu_phase_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        HALT = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        F2   = 3'd3,
        DEC  = 3'd4,
        EXEC = 3'd5,
        ERR  = 3'd7
    } state_t;

    localparam int WW = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W:0]   len_q;
    logic [WW-1:0]     wait_q;
    logic [31:0]       count_q;
    logic [OPW-1:0]    opcode;
    logic              halt_op, waiting, timed_out, step_done, last_step, retire;

    assign opcode    = bus.ir[DATA_W-1 -: OPW];
    assign halt_op   = opcode == OPW'(HALT_OP);
    assign waiting   = bus.mem_req & ~bus.mem_ready;
    assign timed_out = waiting & (wait_q == WW'(TIMEOUT - 1));
    assign step_done = (state == EXEC) & (~bus.step_mem | bus.mem_ready);
    assign last_step = {1'b0, step_q} == len_q - (STEP_W + 1)'(1);
    assign retire    = ((state == DEC) & halt_op) | (step_done & last_step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= HALT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            HALT:    state_nx = bus.run_req & ~bus.stop ? F0 : HALT;
            F0:      state_nx = F1;
            F1:      state_nx = bus.mem_ready ? F2 : timed_out ? ERR : F1;
            F2:      state_nx = DEC;
            DEC:     state_nx = halt_op ? HALT : EXEC;
            EXEC:    state_nx = timed_out ? ERR : retire ? (bus.stop ? HALT : F0) : EXEC;
            default: state_nx = ERR;
        endcase
    end

    always_comb begin
        bus.mem_req     = (state == F1) | ((state == EXEC) & bus.step_mem);
        bus.phase       = state;
        bus.step        = state == EXEC ? step_q : '0;
        bus.pcout_marin = state == F0;
        bus.incpc       = state == F0;
        bus.mdrin       = (state == F1) & bus.mem_ready;
        bus.irin        = state == F2;
        bus.run         = (state != HALT) & (state != ERR);
        bus.bus_err     = state == ERR;
        bus.instr_count = count_q;
    end

    // wait_q restarts from zero whenever a request completes or is not being made
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q  <= '0;
            len_q   <= '0;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            len_q   <= state != DEC ? len_q :
                       bus.exec_len == '0 ? (STEP_W + 1)'(2 ** STEP_W) : {1'b0, bus.exec_len};
            step_q  <= state != EXEC ? '0 : step_done ? (last_step ? '0 : step_q + 1'b1) : step_q;
            wait_q  <= waiting ? wait_q + 1'b1 : '0;
            count_q <= count_q + 32'(retire);
        end
    end
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: builds an expected per-cycle trace from instruction descriptors
// (fetch waits, exec length, per-step memory waits) and checks the sequencer against it.
module tb_cpu_phase_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_phase_sequencer_if #(.DATA_W(32), .STEP_W(3)) bus ();

    cpu_phase_sequencer #(
        .DATA_W(32), .OPW(5), .HALT_OP(27), .STEP_W(3), .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  elen;
        logic [3:0]  fw;
        logic [7:0]  mm;
        logic [31:0] sw;
    } ins_t;

    typedef struct packed {
        logic [2:0]  ph;
        logic [2:0]  st;
        logic        req;
        logic        mdr;
        logic        rdy;
        logic        smem;
        logic        stp;
        logic        ret;
        logic [31:0] ir;
        logic [2:0]  el;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_cnt;
    ins_t        prog[$];
    ent_t        plan[$];

    function automatic logic [3:0] rwait();
        int r;
        r = $urandom_range(0, 4);
        return r < 2 ? 4'd0 : r == 2 ? 4'd1 : r == 3 ? 4'd14 : 4'($urandom_range(0, 14));
    endfunction

    function automatic logic [4:0] rop();
        logic [4:0] o;
        o = 5'($urandom);
        return o == 5'd27 ? 5'd3 : o;
    endfunction

    function automatic ins_t mk(input logic [4:0] op, input logic [2:0] elen,
                                input logic [3:0] fw, input logic [7:0] mm, input logic [31:0] sw);
        ins_t q;
        q.op = op; q.elen = elen; q.fw = fw; q.mm = mm; q.sw = sw;
        return q;
    endfunction

    task automatic idle();
        bus.run_req = 1'b0; bus.stop = 1'b0; bus.ir = '0;
        bus.exec_len = '0; bus.step_mem = 1'b0; bus.mem_ready = 1'b0;
    endtask

    // Trace: HALT with run_req, then F0, F1 x (fw+1), F2, DEC, then each exec step lasting
    // one cycle or (wait+1) cycles when it touches memory. Stop rises mid-way through the
    // last instruction's execute phase so it retires into HALT.
    task automatic build();
        ent_t e;
        ins_t q;
        int   len;
        bit   last;
        plan.delete();
        e = '0; e.rdy = 1'($urandom); e.el = 3'($urandom);
        plan.push_back(e);
        for (int i = 0; i < prog.size(); i++) begin
            q = prog[i];
            last = i == prog.size() - 1;
            e = '0; e.ir = {q.op, 27'($urandom)};
            e.ph = 3'd1; e.rdy = 1'($urandom); e.smem = 1'($urandom); e.el = 3'($urandom);
            plan.push_back(e);
            for (int w = 0; w <= int'(q.fw); w++) begin
                e.ph = 3'd2; e.req = 1'b1; e.rdy = w == int'(q.fw); e.mdr = e.rdy;
                e.smem = 1'($urandom);
                plan.push_back(e);
            end
            e.req = 1'b0; e.mdr = 1'b0; e.ph = 3'd3; e.rdy = 1'($urandom);
            plan.push_back(e);
            e.ph = 3'd4; e.el = q.elen; e.rdy = 1'($urandom); e.ret = q.op == 5'd27;
            plan.push_back(e);
            if (e.ret) continue;
            len = q.elen == 3'd0 ? 8 : int'(q.elen);
            for (int k = 0; k < len; k++) begin
                e.ph = 3'd5; e.st = 3'(k); e.stp = last && k >= (len > 1 ? 1 : 0);
                if (q.mm[k]) begin
                    for (int w = 0; w <= int'(q.sw[k*4 +: 4]); w++) begin
                        e.req = 1'b1; e.smem = 1'b1; e.rdy = w == int'(q.sw[k*4 +: 4]);
                        e.ret = e.rdy && k == len - 1; e.el = 3'($urandom);
                        plan.push_back(e);
                    end
                end else begin
                    e.req = 1'b0; e.smem = 1'b0; e.rdy = 1'($urandom);
                    e.ret = k == len - 1; e.el = 3'($urandom);
                    plan.push_back(e);
                end
            end
        end
    endtask

    task automatic run_plan(input string name);
        ent_t        p;
        logic [12:0] gv, ev;
        for (int i = 0; i < plan.size(); i++) begin
            p = plan[i];
            bus.run_req = i == 0; bus.stop = p.stp; bus.ir = p.ir; bus.exec_len = p.el;
            bus.step_mem = p.smem; bus.mem_ready = p.rdy;
            @(negedge clk);
            gv = {bus.phase, bus.step, bus.mem_req, bus.pcout_marin, bus.incpc, bus.mdrin,
                  bus.irin, bus.run, bus.bus_err};
            ev = {p.ph, p.st, p.req, p.ph == 3'd1, p.ph == 3'd1, p.mdr, p.ph == 3'd3,
                  p.ph != 3'd0, 1'b0};
            total++;
            if (gv !== ev) begin
                bad++;
                $display("FAIL %s cycle %0d outputs got=%b exp=%b", name, i, gv, ev);
            end
            total++;
            if (bus.instr_count !== exp_cnt) begin
                bad++;
                $display("FAIL %s cycle %0d instr_count got=%0d exp=%0d", name, i, bus.instr_count, exp_cnt);
            end
            if (p.ret) exp_cnt++;
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        total++;
        if (bus.phase !== 3'd0 || bus.instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL %s end phase=%0d count=%0d exp phase=0 count=%0d", name, bus.phase, bus.instr_count, exp_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        logic [44:0] gv;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        gv = {bus.phase, bus.step, bus.mem_req, bus.pcout_marin, bus.incpc, bus.mdrin,
              bus.irin, bus.run, bus.bus_err, bus.instr_count};
        total++;
        if (gv !== '0) begin
            bad++;
            $display("FAIL reset outputs got=%h exp=0", gv);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        total++;
        if (bus.phase !== 3'd0 || bus.run !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle phase=%0d run=%b exp phase=0 run=0", bus.phase, bus.run);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        prog.delete();
        prog.push_back(mk(5'd1, 3'd3, 4'd0, 8'h00, '0));
        prog.push_back(mk(5'd1, 3'd3, 4'd0, 8'h00, '0));
        build();
        run_plan("basic");
    endtask

    task automatic test_fetch_wait();
        prog.delete();
        prog.push_back(mk(5'd2, 3'd2, 4'd2, 8'h00, '0));
        prog.push_back(mk(5'd4, 3'd1, 4'd14, 8'h01, 32'h0000_000e));
        build();
        run_plan("fetch_wait");
    endtask

    task automatic test_len0_and_halt_op();
        prog.delete();
        prog.push_back(mk(5'd9, 3'd0, 4'd0, 8'ha5, 32'h1020_3e01));
        prog.push_back(mk(5'd27, 3'd5, 4'd1, 8'h00, '0));
        build();
        run_plan("len0_halt_op");
    endtask

    task automatic test_back_to_back();
        prog.delete();
        repeat (6) prog.push_back(mk(rop(), 3'd1, 4'd0, 8'h00, '0));
        build();
        run_plan("back_to_back");
    endtask

    task automatic test_random();
        ins_t q;
        repeat (5) begin
            prog.delete();
            repeat ($urandom_range(1, 5)) begin
                q = mk(rop(), 3'($urandom), rwait(), 8'($urandom), '0);
                for (int k = 0; k < 8; k++) q.sw[k*4 +: 4] = rwait();
                prog.push_back(q);
            end
            if ($urandom_range(0, 1) == 1) prog.push_back(mk(5'd27, 3'($urandom), rwait(), 8'h00, '0));
            build();
            run_plan("random");
        end
    endtask

    task automatic test_stop();
        prog.delete();
        prog.push_back(mk(5'd6, 3'd3, 4'd0, 8'h00, '0));
        build();
        run_plan("stop_mid_exec");
        bus.run_req = 1'b1; bus.stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.phase !== 3'd0) begin
                bad++;
                $display("FAIL stop_wins cycle %0d phase=%0d exp=0", i, bus.phase);
            end
            @(posedge clk); #1;
        end
        bus.stop = 1'b0;
        @(posedge clk); #1;
        bus.run_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.phase !== 3'd1) begin
            bad++;
            $display("FAIL run_after_stop phase=%0d exp=1", bus.phase);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_timeout();
        int n;
        bit err;
        idle();
        bus.run_req = 1'b1;
        @(posedge clk); #1;
        bus.run_req = 1'b0;
        n = 0; err = 0;
        for (int i = 0; i < 40 && !err; i++) begin
            @(negedge clk);
            if (bus.phase == 3'd2) n++;
            if (bus.phase == 3'd7) err = 1;
        end
        total++;
        if (!err || n != 15) begin
            bad++;
            $display("FAIL fetch_timeout err=%0d f1_cycles=%0d exp err=1 f1_cycles=15", err, n);
        end
        bus.step_mem = 1'b1; bus.run_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'($urandom);
            @(negedge clk);
            total++;
            if ({bus.phase, bus.bus_err, bus.run, bus.mem_req} !== 6'b111_100) begin
                bad++;
                $display("FAIL err_sticky phase=%0d bus_err=%b run=%b mem_req=%b exp 7/1/0/0",
                         bus.phase, bus.bus_err, bus.run, bus.mem_req);
            end
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.phase !== 3'd0 || bus.bus_err !== 1'b0) begin
            bad++;
            $display("FAIL err_reset phase=%0d bus_err=%b exp phase=0 bus_err=0", bus.phase, bus.bus_err);
        end
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
        bus.run_req = 1'b1; bus.mem_ready = 1'b1; bus.exec_len = 3'd1; bus.step_mem = 1'b1;
        @(posedge clk); #1;
        bus.run_req = 1'b0;
        n = 0; err = 0;
        for (int i = 0; i < 40 && !err; i++) begin
            @(negedge clk);
            if (bus.phase == 3'd5) begin
                n++;
                bus.mem_ready = 1'b0;
            end
            if (bus.phase == 3'd7) err = 1;
        end
        total++;
        if (!err || n != 15) begin
            bad++;
            $display("FAIL exec_timeout err=%0d exec_cycles=%0d exp err=1 exec_cycles=15", err, n);
        end
        @(posedge clk); #1;
        idle();
        do_reset();
    endtask

    task automatic test_async_reset();
        int n;
        idle();
        bus.run_req = 1'b1; bus.mem_ready = 1'b1; bus.exec_len = 3'd2; bus.step_mem = 1'b1;
        @(posedge clk); #1;
        bus.run_req = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (bus.phase == 3'd5) begin
                n++;
                bus.mem_ready = 1'b0;
            end
        end
        total++;
        if (bus.phase !== 3'd5 || bus.mem_req !== 1'b1) begin
            bad++;
            $display("FAIL exec_wait phase=%0d mem_req=%b exp phase=5 mem_req=1", bus.phase, bus.mem_req);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus.phase, bus.step, bus.mem_req, bus.run, bus.bus_err, bus.instr_count} !== '0) begin
            bad++;
            $display("FAIL async_reset phase=%0d step=%0d mem_req=%b run=%b count=%0d exp all 0",
                     bus.phase, bus.step, bus.mem_req, bus.run, bus.instr_count);
        end
        idle();
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fetch_wait();
        test_len0_and_halt_op();
        test_back_to_back();
        test_random();
        test_stop();
        test_timeout();
        test_async_reset();
        test_basic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
